id_stage_pipe: RTL and testbench

//  Parametrised decode stage with built-in ID/EXE pipeline register for the ARM-subset pipeline.

---
 rtl/id_stage_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ARM-subset decode stage: register file, condition check, RAW hazard detection and ID/EXE
// pipeline register. Define FORWARD_EN for a write-first WB bypass on register reads.
module id_stage_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic              flush,
  input  logic [3:0]        status,
  input  logic [3:0]        exe_dest,
  input  logic              exe_wb_en,
  input  logic [3:0]        mem_dest,
  input  logic              mem_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_value,
  output logic              stall,
  output logic              out_valid,
  output logic              out_wb_en,
  output logic              out_mem_r,
  output logic              out_mem_w,
  output logic              out_b,
  output logic              out_s,
  output logic              out_imm,
  output logic [3:0]        out_exe_cmd,
  output logic [3:0]        out_dest,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [11:0]       out_shift_op,
  output logic [23:0]       out_simm24
);

  localparam logic [4:0] NumRegsW = 5'(NUM_REGS);

  logic [1:0] mode;
  logic [3:0] op, cond, src1, src2;
  logic       s_bit, imm;
  logic       n_f, z_f, c_f, v_f;

  assign mode  = instr[27:26];
  assign op    = instr[24:21];
  assign s_bit = instr[20];
  assign imm   = instr[25];
  assign cond  = instr[31:28];
  assign src1  = instr[19:16];
  assign {n_f, z_f, c_f, v_f} = status;

  logic [3:0] dec_cmd;
  logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s, is_store, is_mov;

  always_comb begin
    dec_cmd  = 4'b0000;
    dec_wb   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_b    = 1'b0;
    dec_s    = 1'b0;
    is_store = 1'b0;
    is_mov   = 1'b0;
    unique case (mode)
      2'b00: begin
        dec_wb = 1'b1;
        dec_s  = s_bit;
        case (op)
          4'b1101: begin dec_cmd = 4'b0001; is_mov = 1'b1; end
          4'b1111: begin dec_cmd = 4'b1001; is_mov = 1'b1; end
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; dec_s = 1'b1; end
          4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; dec_s = 1'b1; end
          default: begin dec_wb = 1'b0; dec_s = 1'b0; end
        endcase
      end
      2'b01: begin
        if (op == 4'b0100) begin
          dec_cmd = 4'b0010;
          if (s_bit) begin
            dec_mr = 1'b1;
            dec_wb = 1'b1;
          end else begin
            dec_mw   = 1'b1;
            is_store = 1'b1;
          end
        end
      end
      2'b10:   dec_b = 1'b1;
      default: ;
    endcase
  end

  logic cond_ok;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign src2 = is_store ? instr[15:12] : instr[3:0];

  // Entries at or above NUM_REGS are never written, so they always read as zero.
  logic [DATA_W-1:0] rf_q [16];
  logic              wb_in_range;

  assign wb_in_range = ({1'b0, wb_dest} < NumRegsW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_in_range) begin
      rf_q[wb_dest] <= wb_value;
    end
  end

  logic [DATA_W-1:0] rn_val, rm_val;
  logic              wb_hit1, wb_hit2;

`ifdef FORWARD_EN
  assign rn_val  = (wb_en && wb_in_range && wb_dest == src1) ? wb_value : rf_q[src1];
  assign rm_val  = (wb_en && wb_in_range && wb_dest == src2) ? wb_value : rf_q[src2];
  assign wb_hit1 = 1'b0;
  assign wb_hit2 = 1'b0;
`else
  assign rn_val  = rf_q[src1];
  assign rm_val  = rf_q[src2];
  assign wb_hit1 = wb_en && (wb_dest == src1);
  assign wb_hit2 = wb_en && (wb_dest == src2);
`endif

  logic src1_used, src2_used, src1_hit, src2_hit, hazard;

  assign src1_used = !is_mov && !dec_b;
  assign src2_used = ((mode == 2'b00) && !imm) || is_store;
  assign src1_hit  = (exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1) || wb_hit1;
  assign src2_hit  = (exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2) || wb_hit2;
  // Condition outcome deliberately does not mask the hazard.
  assign hazard    = in_valid && ((src1_used && src1_hit) || (src2_used && src2_hit));
  assign stall     = rst && hazard && !flush;

  logic en_gate;
  assign en_gate = in_valid && cond_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_wb_en    <= 1'b0;
      out_mem_r    <= 1'b0;
      out_mem_w    <= 1'b0;
      out_b        <= 1'b0;
      out_s        <= 1'b0;
      out_imm      <= 1'b0;
      out_exe_cmd  <= '0;
      out_dest     <= '0;
      out_src1     <= '0;
      out_src2     <= '0;
      out_val_rn   <= '0;
      out_val_rm   <= '0;
      out_shift_op <= '0;
      out_simm24   <= '0;
    end else if (flush || hazard) begin
      // Bubble: kill control, let data fields hold.
      out_valid <= 1'b0;
      out_wb_en <= 1'b0;
      out_mem_r <= 1'b0;
      out_mem_w <= 1'b0;
      out_b     <= 1'b0;
      out_s     <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      out_wb_en    <= dec_wb && en_gate;
      out_mem_r    <= dec_mr && en_gate;
      out_mem_w    <= dec_mw && en_gate;
      out_b        <= dec_b && en_gate;
      out_s        <= dec_s && en_gate;
      out_imm      <= imm;
      out_exe_cmd  <= dec_cmd;
      out_dest     <= instr[15:12];
      out_src1     <= src1;
      out_src2     <= src2;
      out_val_rn   <= rn_val;
      out_val_rm   <= rm_val;
      out_shift_op <= instr[11:0];
      out_simm24   <= instr[23:0];
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe (NUM_REGS=8); expectations adapt to FORWARD_EN.
module tb_id_stage_pipe;

  localparam logic [3:0] CondAl = 4'hE;
  localparam logic [3:0] OpAdd  = 4'b0100;
  localparam logic [3:0] OpMov  = 4'b1101;

  logic        clk, rst, in_valid, flush, exe_wb_en, mem_wb_en, wb_en;
  logic [31:0] instr, wb_value;
  logic [3:0]  status, exe_dest, mem_dest, wb_dest;
  logic        stall, out_valid, out_wb_en, out_mem_r, out_mem_w, out_b, out_s, out_imm;
  logic [3:0]  out_exe_cmd, out_dest, out_src1, out_src2;
  logic [31:0] out_val_rn, out_val_rm;
  logic [11:0] out_shift_op;
  logic [23:0] out_simm24;

  id_stage_pipe #(.DATA_W(32), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .flush(flush), .status(status),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .wb_dest(wb_dest), .wb_en(wb_en), .wb_value(wb_value), .stall(stall),
    .out_valid(out_valid), .out_wb_en(out_wb_en), .out_mem_r(out_mem_r),
    .out_mem_w(out_mem_w), .out_b(out_b), .out_s(out_s), .out_imm(out_imm),
    .out_exe_cmd(out_exe_cmd), .out_dest(out_dest), .out_src1(out_src1),
    .out_src2(out_src2), .out_val_rn(out_val_rn), .out_val_rm(out_val_rm),
    .out_shift_op(out_shift_op), .out_simm24(out_simm24)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  typedef struct packed {
    logic        valid, wb, mr, mw, b, s, chk_cmd;
    logic [3:0]  cmd;
    logic        chk_data;
    logic [31:0] rn, rm;
    logic [3:0]  src2;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, wb, mr, mw, b, s, input logic [3:0] cmd,
                              input logic [31:0] rn, rm, input logic [3:0] src2);
    exp_t e;
    e = '{valid: v, wb: wb, mr: mr, mw: mw, b: b, s: s, chk_cmd: 1'b1, cmd: cmd,
          chk_data: 1'b1, rn: rn, rm: rm, src2: src2};
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic logic [31:0] enc(input logic [3:0] cond, input logic [1:0] mode,
                                      input logic imm, input logic [3:0] op, input logic s,
                                      input logic [3:0] rn, rd, rm);
    return {cond, mode, imm, op, s, rn, rd, 8'h00, rm};
  endfunction

  // Drive one decode cycle from a negedge; the expected result waits in the scoreboard
  // until the registered outputs update.
  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic exp_stall, input exp_t e);
    exp_t x;
    instr = ins;
    in_valid = v;
    #1;
    check_eq({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(x.valid));
    check_eq({tag, ".en"}, 64'({out_wb_en, out_mem_r, out_mem_w, out_b, out_s}),
             64'({x.wb, x.mr, x.mw, x.b, x.s}));
    if (x.chk_cmd) check_eq({tag, ".cmd"}, 64'(out_exe_cmd), 64'(x.cmd));
    if (x.chk_data) begin
      check_eq({tag, ".rn"}, 64'(out_val_rn), 64'(x.rn));
      check_eq({tag, ".rm"}, 64'(out_val_rm), 64'(x.rm));
      check_eq({tag, ".src2"}, 64'(out_src2), 64'(x.src2));
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] val);
    in_valid = 1'b0;
    wb_en = 1'b1;
    wb_dest = idx;
    wb_value = val;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  logic [3:0] op_tab [12], cmd_tab [12];
  logic       wb_tab [12], s_tab [12], nop_tab [12];
  logic [3:0] cnd_tab [15], st_tab [15];
  logic       pass_tab [15];
  logic [31:0] add123;

  initial begin
    op_tab   = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8, 4'h3};
    cmd_tab  = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h4, 4'h6, 4'h0};
    wb_tab   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    s_tab    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    nop_tab  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    cnd_tab  = '{4'h0, 4'h0, 4'h1, 4'h8, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'h2, 4'h4,
                 4'h7, 4'h9, 4'hE};
    st_tab   = '{4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0110, 4'b1001, 4'b1000, 4'b0001,
                 4'b1000, 4'b0100, 4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
    pass_tab = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1};
    add123   = enc(CondAl, 2'b00, 1'b0, OpAdd, 1'b0, 4'd2, 4'd1, 4'd3);

    // Reset with a hazard-shaped input present: stall must still read 0.
    rst = 1'b0; in_valid = 1'b1; instr = add123; flush = 1'b0; status = 4'b0000;
    exe_dest = 4'd2; exe_wb_en = 1'b1; mem_dest = '0; mem_wb_en = 1'b0;
    wb_dest = '0; wb_en = 1'b0; wb_value = '0;
    #1;
    check_eq("rst.stall", 64'(stall), 64'd0);
    check_eq("rst.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.ctrl", 64'({out_valid, out_wb_en, out_exe_cmd}), 64'd0);
    check_eq("rst.rn", 64'(out_val_rn), 64'd0);
    in_valid = 1'b0; exe_dest = '0; exe_wb_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 1; i < 8; i++)
      step($sformatf("rd0_r%0d", i), enc(CondAl, 2'b00, 1'b0, OpAdd, 1'b0, 4'(i), 4'd0, 4'(i)),
           1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd0, 32'd0, 4'(i)));

    wr(4'd2, 32'd5);
    wr(4'd3, 32'd7);
    step("add", add123, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd5, 32'd7, 4'd3));

    for (int i = 0; i < 12; i++) begin
      exp_t e;
      e = mk(1, wb_tab[i], 0, 0, 0, s_tab[i], cmd_tab[i], 32'd5, 32'd7, 4'd3);
      e.chk_cmd = !nop_tab[i];
      step($sformatf("op%0h", op_tab[i]),
           enc(CondAl, 2'b00, 1'b0, op_tab[i], 1'b0, 4'd2, 4'd1, 4'd3), 1'b1, 1'b0, e);
    end
    step("adds", enc(CondAl, 2'b00, 1'b0, OpAdd, 1'b1, 4'd2, 4'd1, 4'd3), 1'b1, 1'b0,
         mk(1, 1, 0, 0, 0, 1, 4'h2, 32'd5, 32'd7, 4'd3));
    step("mode11", enc(CondAl, 2'b11, 1'b0, OpAdd, 1'b0, 4'd2, 4'd1, 4'd3), 1'b1, 1'b0,
         '{valid: 1, chk_data: 1, rn: 32'd5, rm: 32'd7, src2: 4'd3, default: '0});

    exe_dest = 4'd2; exe_wb_en = 1'b1;
    step("hz_exe", add123, 1'b1, 1'b1, bub());
    step("hz_mov", enc(CondAl, 2'b00, 1'b0, OpMov, 1'b0, 4'd2, 4'd1, 4'd3), 1'b1, 1'b0,
         mk(1, 1, 0, 0, 0, 0, 4'h1, 32'd5, 32'd7, 4'd3));
    step("hz_br", enc(CondAl, 2'b10, 1'b0, 4'h0, 1'b0, 4'd2, 4'd1, 4'd3), 1'b1, 1'b0,
         mk(1, 0, 0, 0, 1, 0, 4'h0, 32'd5, 32'd7, 4'd3));
    step("hz_imm", enc(CondAl, 2'b00, 1'b1, OpAdd, 1'b0, 4'd3, 4'd1, 4'd2), 1'b1, 1'b0,
         mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd7, 32'd5, 4'd2));
    step("hz_inv", add123, 1'b0, 1'b0, bub());
    status = 4'b0000;
    step("hz_cfail", enc(4'h0, 2'b00, 1'b0, OpAdd, 1'b0, 4'd2, 4'd1, 4'd3), 1'b1, 1'b1, bub());
    flush = 1'b1;
    step("flush_hz", add123, 1'b1, 1'b0, bub());
    exe_wb_en = 1'b0;
    step("flush", add123, 1'b1, 1'b0, bub());
    flush = 1'b0;
    step("hz_clear", add123, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd5, 32'd7, 4'd3));
    mem_dest = 4'd3; mem_wb_en = 1'b1;
    step("hz_mem", add123, 1'b1, 1'b1, bub());
    mem_wb_en = 1'b0;

    for (int i = 0; i < 15; i++) begin
      status = st_tab[i];
      step($sformatf("cond%0h_%0d", cnd_tab[i], i),
           enc(cnd_tab[i], 2'b00, 1'b0, OpAdd, 1'b1, 4'd2, 4'd1, 4'd3), 1'b1, 1'b0,
           mk(1, pass_tab[i], 0, 0, 0, pass_tab[i], 4'h2, 32'd5, 32'd7, 4'd3));
    end
    status = 4'b0000;

    step("ldr", enc(CondAl, 2'b01, 1'b0, 4'b0100, 1'b1, 4'd3, 4'd6, 4'd2), 1'b1, 1'b0,
         mk(1, 1, 1, 0, 0, 0, 4'h2, 32'd7, 32'd5, 4'd2));

    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd9;
`ifdef FORWARD_EN
    step("wb_fwd", add123, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd9, 32'd7, 4'd3));
    wb_en = 1'b0;
`else
    step("wb_stall", add123, 1'b1, 1'b1, bub());
    wb_en = 1'b0;
    step("wb_after", add123, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd9, 32'd7, 4'd3));
`endif

    wr(4'd4, 32'h11);
    wr(4'd12, 32'h55);
    step("rd_r12", enc(CondAl, 2'b00, 1'b0, OpAdd, 1'b0, 4'd12, 4'd0, 4'd12), 1'b1, 1'b0,
         mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd0, 32'd0, 4'd12));
    step("str", enc(CondAl, 2'b01, 1'b0, 4'b0100, 1'b0, 4'd5, 4'd4, 4'd0), 1'b1, 1'b0,
         mk(1, 0, 0, 1, 0, 0, 4'h2, 32'd0, 32'h11, 4'd4));
    exe_dest = 4'd4; exe_wb_en = 1'b1;
    step("str_hz", enc(CondAl, 2'b01, 1'b0, 4'b0100, 1'b0, 4'd5, 4'd4, 4'd0), 1'b1, 1'b1,
         bub());
    exe_wb_en = 1'b0; exe_dest = '0;

    step("pre_rst", add123, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd9, 32'd7, 4'd3));
    rst = 1'b0;
    #1;
    check_eq("midrst.ctrl", 64'({out_valid, out_wb_en, out_exe_cmd}), 64'd0);
    check_eq("midrst.rn", 64'(out_val_rn), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", add123, 1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0, 4'h2, 32'd0, 32'd0, 4'd3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
